// File: rtl/mlp_train_sequencer_if.sv
`default_nettype none
// ============================================================================
// mlp_train_sequencer_if : host load/start port and MLP sample-side port
// Revision: 1.0
// ============================================================================
interface mlp_train_sequencer_if #(
  parameter int INPUTS  = 2,
  parameter int OUTPUTS = 1,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16
);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic                              load_valid;
  logic                              load_ready;
  logic [IW-1:0]                     load_index;
  logic [INPUTS-1:0][WIDTH-1:0]      load_values;
  logic [OUTPUTS-1:0][WIDTH-1:0]     load_expected;
  logic [NW-1:0]                     num_samples;
  logic [15:0]                       num_epochs;
  logic                              train_mode;
  logic                              start;
  logic                              busy;
  logic                              done;
  logic [INPUTS-1:0][WIDTH-1:0]      mlp_values;
  logic [OUTPUTS-1:0][WIDTH-1:0]     mlp_expected;
  logic                              mlp_training;
  logic [OUTPUTS-1:0][WIDTH-1:0]     mlp_prediction;
  logic                              result_valid;
  logic [IW-1:0]                     result_index;
  logic [OUTPUTS-1:0][WIDTH-1:0]     result_prediction;
  logic [15:0]                       epoch_count;
  logic [WIDTH-1:0]                  epoch_error;
  logic                              epoch_error_valid;

  modport slave (
    input  load_valid, load_index, load_values, load_expected,
           num_samples, num_epochs, train_mode, start, mlp_prediction,
    output load_ready, busy, done, mlp_values, mlp_expected, mlp_training,
           result_valid, result_index, result_prediction,
           epoch_count, epoch_error, epoch_error_valid
  );

  modport master (
    output load_valid, load_index, load_values, load_expected,
           num_samples, num_epochs, train_mode, start, mlp_prediction,
    input  load_ready, busy, done, mlp_values, mlp_expected, mlp_training,
           result_valid, result_index, result_prediction,
           epoch_count, epoch_error, epoch_error_valid
  );
endinterface
`default_nettype wire

// File: rtl/mlp_train_sequencer.sv
`default_nettype none
// ============================================================================
// mlp_train_sequencer : dataset store and epoch sequencer for an MLP sample port
// Revision: 1.0
// ============================================================================
module mlp_train_sequencer #(
  parameter int INPUTS        = 2,
  parameter int OUTPUTS       = 1,
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH         = 16
) (
  input wire clk,
  input wire rst,
  mlp_train_sequencer_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WIDTH-1:0] SFP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SFP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [INPUTS-1:0][WIDTH-1:0]  mem_values   [DEPTH];
  logic [OUTPUTS-1:0][WIDTH-1:0] mem_expected [DEPTH];

  logic [IW-1:0]    idx;
  logic [SW-1:0]    settle_cnt;
  logic [NW-1:0]    run_samples;
  logic [15:0]      run_epochs;
  logic             run_train;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             index_ok;
  logic             start_ok;
  logic             empty_run;
  logic             last_sample;
  logic             last_epoch;
  logic             settle_end;

  function automatic logic [WIDTH-1:0] sfp_sat(input logic [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1]) return x[WIDTH] ? SFP_MIN : SFP_MAX;
    return x[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sfp_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return sfp_sat({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic logic [WIDTH-1:0] sfp_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return sfp_sat({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  function automatic logic [WIDTH-1:0] sfp_abs(input logic [WIDTH-1:0] a);
    if (a == SFP_MIN) return SFP_MAX;
    return a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  endfunction

  // Out-of-range writes can only occur when DEPTH leaves unused index codes.
  generate
    if ((1 << IW) == DEPTH) begin : g_index_full
      assign index_ok = 1'b1;
    end else begin : g_index_range
      assign index_ok = (int'(bus.load_index) < DEPTH);
    end
  endgenerate

  assign start_ok    = (state == S_IDLE) && bus.start;
  assign empty_run   = (bus.num_samples == '0) || (bus.num_epochs == 16'd0);
  assign last_sample = ((NW'(idx) + NW'(1)) == run_samples);
  assign last_epoch  = ((bus.epoch_count + 16'd1) == run_epochs);
  assign settle_end  = (settle_cnt == SW'(SETTLE_CYCLES - 1));

  always_comb begin
    acc_next = acc;
    for (int o = 0; o < OUTPUTS; o++) begin
      acc_next = sfp_add(acc_next,
                         sfp_abs(sfp_sub(mem_expected[idx][o], bus.mlp_prediction[o])));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_ok) state_next = empty_run ? S_DONE : S_APPLY;
      S_APPLY:   if (settle_end) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_UPDATE;
      S_UPDATE:  state_next = (last_sample && last_epoch) ? S_DONE : S_APPLY;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Dataset storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bus.load_valid && bus.load_ready && index_ok) begin
      mem_values[bus.load_index]   <= bus.load_values;
      mem_expected[bus.load_index] <= bus.load_expected;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                   <= '0;
      settle_cnt            <= '0;
      run_samples           <= '0;
      run_epochs            <= '0;
      run_train             <= 1'b0;
      acc                   <= '0;
      bus.load_ready        <= 1'b0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.mlp_values        <= '0;
      bus.mlp_expected      <= '0;
      bus.mlp_training      <= 1'b0;
      bus.result_valid      <= 1'b0;
      bus.result_index      <= '0;
      bus.result_prediction <= '0;
      bus.epoch_count       <= '0;
      bus.epoch_error       <= '0;
      bus.epoch_error_valid <= 1'b0;
    end else begin
      bus.load_ready        <= (state_next == S_IDLE);
      bus.busy              <= (state_next != S_IDLE);
      bus.done              <= 1'b0;
      bus.mlp_training      <= 1'b0;
      bus.result_valid      <= 1'b0;
      bus.epoch_error_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            run_samples     <= bus.num_samples;
            run_epochs      <= bus.num_epochs;
            run_train       <= bus.train_mode;
            bus.epoch_count <= '0;
            acc             <= '0;
            idx             <= '0;
            settle_cnt      <= '0;
          end
        end
        S_APPLY: begin
          bus.mlp_values   <= mem_values[idx];
          bus.mlp_expected <= mem_expected[idx];
          settle_cnt       <= settle_end ? '0 : settle_cnt + SW'(1);
        end
        S_CAPTURE: begin
          bus.result_prediction <= bus.mlp_prediction;
          bus.result_index      <= idx;
          bus.result_valid      <= 1'b1;
          acc                   <= acc_next;
        end
        S_UPDATE: begin
          bus.mlp_training <= run_train;
          if (last_sample) begin
            bus.epoch_error       <= acc;
            bus.epoch_error_valid <= 1'b1;
            bus.epoch_count       <= bus.epoch_count + 16'd1;
            acc                   <= '0;
            idx                   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE:  bus.done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
